// File: rtl/rv_decode_stage.sv
// RV32I decode stage: instruction buffer feeding a registered decode bundle (M extension under RV_M_EXT_EN).
// Latency: a word accepted at edge N appears on the decode outputs after edge N+1; throughput is 1/cycle.
// Backpressure: instr_ready_o depends only on occupancy, flush and reset, never combinationally on dec_ready_i.
module rv_decode_stage #(
    parameter int IBUF_DEPTH = 4,
    parameter int ALU_CTRL_W = 12,
    parameter int CNT_W      = $clog2(IBUF_DEPTH) + 1
) (
    input  logic                  risc_clk,
    input  logic                  risc_rst,
    input  logic                  flush_i,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [31:0]           instruction_i,
    output logic                  dec_valid_o,
    input  logic                  dec_ready_i,
    output logic [6:0]            opcode_o,
    output logic [2:0]            func3_o,
    output logic [6:0]            func7_o,
    output logic [4:0]            rs1_o,
    output logic [4:0]            rs2_o,
    output logic [4:0]            rd_o,
    output logic [31:0]           imm_o,
    output logic                  reg_wr_en_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic                  mem_to_reg_en_o,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  invalid_instruction_valid_o,
    output logic [CNT_W-1:0]      ibuf_count_o
);

    localparam int PTR_W = $clog2(IBUF_DEPTH);

    localparam int A_ADD    = 0;
    localparam int A_SUB    = 1;
    localparam int A_SLL    = 2;
    localparam int A_SLT    = 3;
    localparam int A_SLTU   = 4;
    localparam int A_XOR    = 5;
    localparam int A_SRL    = 6;
    localparam int A_SRA    = 7;
    localparam int A_OR     = 8;
    localparam int A_AND    = 9;
    localparam int A_COPY_B = 10;
    localparam int A_MUL    = 11;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [31:0]           instr;
        logic [31:0]           imm;
        logic                  reg_wr;
        logic                  mem_rd;
        logic                  mem_wr;
        logic                  mem_to_reg;
        logic [ALU_CTRL_W-1:0] alu;
        logic                  illegal;
    } dec_t;

    logic [31:0]      ibuf [IBUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic [31:0]      head;
    dec_t             dec_d;
    dec_t             dec_q;
    logic             dec_vld;

    assign instr_ready_o = (count < CNT_W'(IBUF_DEPTH)) && !flush_i && !risc_rst;
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = (!dec_vld || dec_ready_i) && (count != '0) && !flush_i;
    assign head          = ibuf[rd_ptr];

    // Decode the buffer head combinationally; the result is captured on pop.
    always_comb begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        opc   = head[6:0];
        f3    = head[14:12];
        f7    = head[31:25];
        imm_i = {{20{head[31]}}, head[31:20]};
        imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
        imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
        imm_u = {head[31:12], 12'b0};
        imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};

        dec_d       = '0;
        dec_d.instr = head;

        case (opc)
            OPC_LUI: begin
                dec_d.imm = imm_u; dec_d.reg_wr = 1'b1; dec_d.alu[A_COPY_B] = 1'b1;
            end
            OPC_AUIPC: begin
                dec_d.imm = imm_u; dec_d.reg_wr = 1'b1; dec_d.alu[A_ADD] = 1'b1;
            end
            OPC_JAL: begin
                dec_d.imm = imm_j; dec_d.reg_wr = 1'b1; dec_d.alu[A_ADD] = 1'b1;
            end
            OPC_JALR: begin
                dec_d.imm = imm_i; dec_d.reg_wr = 1'b1; dec_d.alu[A_ADD] = 1'b1;
                if (f3 != 3'b000) dec_d.illegal = 1'b1;
            end
            OPC_BRANCH: begin
                dec_d.imm = imm_b; dec_d.alu[A_SUB] = 1'b1;
                if (f3 == 3'b010 || f3 == 3'b011) dec_d.illegal = 1'b1;
            end
            OPC_LOAD: begin
                dec_d.imm = imm_i; dec_d.reg_wr = 1'b1; dec_d.alu[A_ADD] = 1'b1;
                dec_d.mem_rd = 1'b1; dec_d.mem_to_reg = 1'b1;
                if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) dec_d.illegal = 1'b1;
            end
            OPC_STORE: begin
                dec_d.imm = imm_s; dec_d.mem_wr = 1'b1; dec_d.alu[A_ADD] = 1'b1;
                if (f3 > 3'b010) dec_d.illegal = 1'b1;
            end
            OPC_OPIMM: begin
                dec_d.imm = imm_i; dec_d.reg_wr = 1'b1;
                case (f3)
                    3'b000: dec_d.alu[A_ADD]  = 1'b1;
                    3'b010: dec_d.alu[A_SLT]  = 1'b1;
                    3'b011: dec_d.alu[A_SLTU] = 1'b1;
                    3'b100: dec_d.alu[A_XOR]  = 1'b1;
                    3'b110: dec_d.alu[A_OR]   = 1'b1;
                    3'b111: dec_d.alu[A_AND]  = 1'b1;
                    3'b001: begin
                        if (f7 == 7'b0000000) dec_d.alu[A_SLL] = 1'b1;
                        else                  dec_d.illegal    = 1'b1;
                    end
                    default: begin
                        if (f7 == 7'b0000000)      dec_d.alu[A_SRL] = 1'b1;
                        else if (f7 == 7'b0100000) dec_d.alu[A_SRA] = 1'b1;
                        else                       dec_d.illegal    = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                dec_d.reg_wr = 1'b1;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  dec_d.alu[A_ADD]  = 1'b1;
                            3'b001:  dec_d.alu[A_SLL]  = 1'b1;
                            3'b010:  dec_d.alu[A_SLT]  = 1'b1;
                            3'b011:  dec_d.alu[A_SLTU] = 1'b1;
                            3'b100:  dec_d.alu[A_XOR]  = 1'b1;
                            3'b101:  dec_d.alu[A_SRL]  = 1'b1;
                            3'b110:  dec_d.alu[A_OR]   = 1'b1;
                            default: dec_d.alu[A_AND]  = 1'b1;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      dec_d.alu[A_SUB] = 1'b1;
                        else if (f3 == 3'b101) dec_d.alu[A_SRA] = 1'b1;
                        else                   dec_d.illegal    = 1'b1;
                    end
`ifdef RV_M_EXT_EN
                    // func3 (carried on func3_o) picks the specific MUL/DIV/REM op.
                    7'b0000001: dec_d.alu[A_MUL] = 1'b1;
`else
                    7'b0000001: dec_d.illegal = 1'b1;
`endif
                    default: dec_d.illegal = 1'b1;
                endcase
            end
            OPC_FENCE: dec_d.imm = imm_i;
            default:   dec_d.illegal = 1'b1;
        endcase

        if (head[1:0] != 2'b11) dec_d.illegal = 1'b1;

        if (dec_d.illegal) begin
            dec_d.imm        = '0;
            dec_d.reg_wr     = 1'b0;
            dec_d.mem_rd     = 1'b0;
            dec_d.mem_wr     = 1'b0;
            dec_d.mem_to_reg = 1'b0;
            dec_d.alu        = '0;
        end

        if (head[11:7] == 5'd0) dec_d.reg_wr = 1'b0;
    end

    // Storage has no reset; occupancy and pointers define what is meaningful.
    always_ff @(posedge risc_clk) begin
        if (push) ibuf[wr_ptr] <= instruction_i;
    end

    always_ff @(posedge risc_clk) begin
        if (risc_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dec_vld <= 1'b0;
            dec_q   <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dec_vld <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                dec_q   <= dec_d;
                dec_vld <= 1'b1;
            end else if (dec_ready_i) begin
                dec_vld <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign dec_valid_o                 = dec_vld;
    assign opcode_o                    = dec_q.instr[6:0];
    assign func3_o                     = dec_q.instr[14:12];
    assign func7_o                     = dec_q.instr[31:25];
    assign rs1_o                       = dec_q.instr[19:15];
    assign rs2_o                       = dec_q.instr[24:20];
    assign rd_o                        = dec_q.instr[11:7];
    assign imm_o                       = dec_q.imm;
    assign reg_wr_en_o                 = dec_q.reg_wr;
    assign mem_rd_en_o                 = dec_q.mem_rd;
    assign mem_wr_en_o                 = dec_q.mem_wr;
    assign mem_to_reg_en_o             = dec_q.mem_to_reg;
    assign alu_ctrl_o                  = dec_q.alu;
    assign invalid_instruction_valid_o = dec_q.illegal;
    assign ibuf_count_o                = count;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed-vector bench for rv_decode_stage: field decode, immediates, illegal detection, backpressure, flush, reset.
module tb_rv_decode_stage;

    logic        risc_clk = 1'b0;
    logic        risc_rst;
    logic        flush_i;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instruction_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [6:0]  opcode_o;
    logic [2:0]  func3_o;
    logic [6:0]  func7_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic [31:0] imm_o;
    logic        reg_wr_en_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic        mem_to_reg_en_o;
    logic [11:0] alu_ctrl_o;
    logic        invalid_instruction_valid_o;
    logic [2:0]  ibuf_count_o;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 risc_clk = ~risc_clk;

    rv_decode_stage #(.IBUF_DEPTH(4), .ALU_CTRL_W(12)) dut (
        .risc_clk                    (risc_clk),
        .risc_rst                    (risc_rst),
        .flush_i                     (flush_i),
        .instr_valid_i               (instr_valid_i),
        .instr_ready_o               (instr_ready_o),
        .instruction_i               (instruction_i),
        .dec_valid_o                 (dec_valid_o),
        .dec_ready_i                 (dec_ready_i),
        .opcode_o                    (opcode_o),
        .func3_o                     (func3_o),
        .func7_o                     (func7_o),
        .rs1_o                       (rs1_o),
        .rs2_o                       (rs2_o),
        .rd_o                        (rd_o),
        .imm_o                       (imm_o),
        .reg_wr_en_o                 (reg_wr_en_o),
        .mem_rd_en_o                 (mem_rd_en_o),
        .mem_wr_en_o                 (mem_wr_en_o),
        .mem_to_reg_en_o             (mem_to_reg_en_o),
        .alu_ctrl_o                  (alu_ctrl_o),
        .invalid_instruction_valid_o (invalid_instruction_valid_o),
        .ibuf_count_o                (ibuf_count_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge risc_clk);
        #1;
    endtask

    // Push one word into an empty pipeline and advance to the cycle it is presented.
    task automatic issue(input logic [31:0] w);
        instr_valid_i = 1'b1;
        instruction_i = w;
        tick();
        instr_valid_i = 1'b0;
        tick();
    endtask

    task automatic check_ctrl(input string tag, input logic wr, input logic mrd, input logic mwr,
                              input logic m2r, input logic [11:0] alu, input logic ill);
        check({tag, ".valid"},   {31'd0, dec_valid_o}, 32'd1);
        check({tag, ".wr"},      {31'd0, reg_wr_en_o}, {31'd0, wr});
        check({tag, ".mrd"},     {31'd0, mem_rd_en_o}, {31'd0, mrd});
        check({tag, ".mwr"},     {31'd0, mem_wr_en_o}, {31'd0, mwr});
        check({tag, ".m2r"},     {31'd0, mem_to_reg_en_o}, {31'd0, m2r});
        check({tag, ".alu"},     {20'd0, alu_ctrl_o}, {20'd0, alu});
        check({tag, ".illegal"}, {31'd0, invalid_instruction_valid_o}, {31'd0, ill});
    endtask

    function automatic logic [31:0] addi_word(input int k);
        logic [11:0] imm12;
        logic [4:0]  rd;
        imm12 = 12'(k);
        rd    = 5'(k + 1);
        return {imm12, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        risc_rst      = 1'b1;
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        instruction_i = '0;
        dec_ready_i   = 1'b1;
        tick();
        tick();
        check("rst.count", {29'd0, ibuf_count_o}, 32'd0);
        check("rst.valid", {31'd0, dec_valid_o}, 32'd0);
        check("rst.ready", {31'd0, instr_ready_o}, 32'd0);
        check("rst.alu",   {20'd0, alu_ctrl_o}, 32'd0);
        check("rst.imm",   imm_o, 32'd0);
        risc_rst = 1'b0;
        #1;
        check("rst.ready_after", {31'd0, instr_ready_o}, 32'd1);

        // ADD x3,x1,x2 with first-transaction latency
        instr_valid_i = 1'b1;
        instruction_i = 32'h002081B3;
        tick();
        instr_valid_i = 1'b0;
        check("add.lat_valid", {31'd0, dec_valid_o}, 32'd0);
        check("add.lat_count", {29'd0, ibuf_count_o}, 32'd1);
        tick();
        check_ctrl("add", 1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0);
        check("add.rd",  {27'd0, rd_o}, 32'd3);
        check("add.rs1", {27'd0, rs1_o}, 32'd1);
        check("add.rs2", {27'd0, rs2_o}, 32'd2);
        check("add.imm", imm_o, 32'd0);
        check("add.opc", {25'd0, opcode_o}, 32'h33);
        tick();
        check("add.drained", {31'd0, dec_valid_o}, 32'd0);

        issue(32'hFFF00093);
        check_ctrl("addi", 1'b1, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0);
        check("addi.imm", imm_o, 32'hFFFFFFFF);

        issue(32'h0020A423);
        check_ctrl("sw", 1'b0, 1'b0, 1'b1, 1'b0, 12'h001, 1'b0);
        check("sw.imm",   imm_o, 32'd8);
        check("sw.func3", {29'd0, func3_o}, 32'd2);

        issue(32'h00412203);
        check_ctrl("lw", 1'b1, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0);
        check("lw.imm", imm_o, 32'd4);

        issue(32'h123452B7);
        check_ctrl("lui", 1'b1, 1'b0, 1'b0, 1'b0, 12'h400, 1'b0);
        check("lui.imm", imm_o, 32'h12345000);

        issue(32'h00208463);
        check_ctrl("beq", 1'b0, 1'b0, 1'b0, 1'b0, 12'h002, 1'b0);
        check("beq.imm", imm_o, 32'd8);

        issue(32'h00000073);
        check_ctrl("ecall", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        issue(32'h00000000);
        check_ctrl("zero", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
        issue(32'h00000013);
        check_ctrl("nop", 1'b0, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0);

        issue(32'h022081B3);
`ifdef RV_M_EXT_EN
        check_ctrl("mul", 1'b1, 1'b0, 1'b0, 1'b0, 12'h800, 1'b0);
`else
        check_ctrl("mul", 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 1'b1);
`endif
        tick();

        // Backpressure: five words, outputs frozen on word 0, four held in the buffer
        dec_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            instr_valid_i = 1'b1;
            instruction_i = addi_word(k);
            tick();
        end
        instr_valid_i = 1'b0;
        check("bp.count", {29'd0, ibuf_count_o}, 32'd4);
        check("bp.ready", {31'd0, instr_ready_o}, 32'd0);
        check("bp.valid", {31'd0, dec_valid_o}, 32'd1);
        check("bp.imm0",  imm_o, 32'd0);
        tick();
        check("bp.hold_imm", imm_o, 32'd0);
        check("bp.hold_rd",  {27'd0, rd_o}, 32'd1);
        dec_ready_i   = 1'b1;
        instr_valid_i = 1'b1;
        instruction_i = 32'h00000013;
        #1;
        check("bp.full_pop_ready", {31'd0, instr_ready_o}, 32'd0);
        instr_valid_i = 1'b0;
        for (int k = 1; k < 5; k++) begin
            tick();
            check($sformatf("bp.drain%0d", k), imm_o, 32'(k));
            check($sformatf("bp.count%0d", k), {29'd0, ibuf_count_o}, 32'(4 - k));
        end
        tick();
        check("bp.empty_valid", {31'd0, dec_valid_o}, 32'd0);

        // Flush with three buffered words and a competing input
        dec_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            instr_valid_i = 1'b1;
            instruction_i = addi_word(k);
            tick();
        end
        check("fl.pre_count", {29'd0, ibuf_count_o}, 32'd3);
        flush_i       = 1'b1;
        instruction_i = addi_word(9);
        #1;
        check("fl.ready", {31'd0, instr_ready_o}, 32'd0);
        tick();
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        check("fl.count", {29'd0, ibuf_count_o}, 32'd0);
        check("fl.valid", {31'd0, dec_valid_o}, 32'd0);
        tick();
        check("fl.not_captured", {31'd0, dec_valid_o}, 32'd0);
        check("fl.count2", {29'd0, ibuf_count_o}, 32'd0);

        // Mid-stream reset discards everything
        for (int k = 0; k < 3; k++) begin
            instr_valid_i = 1'b1;
            instruction_i = addi_word(k);
            tick();
        end
        instr_valid_i = 1'b0;
        risc_rst = 1'b1;
        tick();
        risc_rst = 1'b0;
        check("mrst.count", {29'd0, ibuf_count_o}, 32'd0);
        check("mrst.valid", {31'd0, dec_valid_o}, 32'd0);
        check("mrst.imm",   imm_o, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
